// File: rtl/data_memory_bytelane.sv
// Byte-addressed 32-bit data memory with sub-word loads/stores, registered
// read port, alignment checking and a post-reset hardware clear sweep.
module data_memory_bytelane #(
  parameter int ADDR_WIDTH     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic        mem_to_reg,
  input  logic [1:0]  access_size,
  input  logic        load_unsigned,
  input  logic [31:0] input_addr,
  input  logic [31:0] input_data,
  output logic [31:0] output_data,
  output logic        read_valid,
  output logic        busy,
  output logic        misaligned
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   clear_ptr_q;
  logic [31:0]             output_data_q;
  logic                    read_valid_q;
  logic                    misaligned_q;
  logic [31:0]             mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [1:0]              off;
  logic                    req_mis;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_widx;
  logic [3:0]              lane_mask;
  logic [31:0]             mem_wdata;
  logic [31:0]             rd_word;
  logic [15:0]             rd_sub;
  logic [31:0]             load_val;
  logic                    unused_addr_bits;

  assign word_idx         = input_addr[ADDR_WIDTH+1:2];
  assign off              = input_addr[1:0];
  assign unused_addr_bits = ^input_addr[31:ADDR_WIDTH+2];

  assign busy        = (state_q == S_CLEAR);
  assign output_data = output_data_q;
  assign read_valid  = read_valid_q;
  assign misaligned  = misaligned_q;

  // Alignment check and store lane steering; the clear sweep overrides the
  // write port with a full-word zero write at clear_ptr_q.
  always_comb begin
    req_mis   = 1'b0;
    lane_mask = '0;
    mem_wdata = '0;
    case (access_size)
      2'b00: begin
        lane_mask = 4'b0001 << off;
        mem_wdata = {4{input_data[7:0]}};
      end
      2'b01: begin
        req_mis   = off[0];
        lane_mask = 4'b0011 << off;
        mem_wdata = {2{input_data[15:0]}};
      end
      2'b10: begin
        req_mis   = (off != 2'b00);
        lane_mask = 4'b1111;
        mem_wdata = input_data;
      end
      default: req_mis = 1'b1;
    endcase

    if (state_q == S_CLEAR) begin
      mem_we    = !reset;
      mem_widx  = clear_ptr_q;
      lane_mask = '1;
      mem_wdata = '0;
    end else begin
      mem_we    = !reset && write_enable && !req_mis;
      mem_widx  = word_idx;
    end
  end

  // Read path sees pre-write contents since the array updates at the edge.
  always_comb begin
    rd_word = mem_q[word_idx];
    rd_sub  = 16'(rd_word >> {off, 3'b000});
    case (access_size)
      2'b00:   load_val = {{24{!load_unsigned && rd_sub[7]}}, rd_sub[7:0]};
      2'b01:   load_val = {{16{!load_unsigned && rd_sub[15]}}, rd_sub};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_mask[i]) mem_q[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clear_ptr_q   <= '0;
      output_data_q <= '0;
      read_valid_q  <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          read_valid_q <= 1'b0;
          misaligned_q <= 1'b0;
          clear_ptr_q  <= clear_ptr_q + ADDR_WIDTH'(1);
          if (&clear_ptr_q) state_q <= S_IDLE;
        end
        default: begin
          read_valid_q <= read_enable;
          misaligned_q <= (read_enable || write_enable) && req_mis;
          if (read_enable) begin
            if (!mem_to_reg)  output_data_q <= input_data;
            else if (req_mis) output_data_q <= '0;
            else              output_data_q <= load_val;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_bytelane.sv
// Testbench for data_memory_bytelane: directed scenarios plus randomized
// traffic checked against a byte-array reference model.
module tb_data_memory_bytelane;

  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;
  localparam int NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic        mem_to_reg = 1'b0;
  logic [1:0]  access_size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] input_addr = '0;
  logic [31:0] input_data = '0;
  logic [31:0] output_data;
  logic        read_valid;
  logic        busy;
  logic        misaligned;

  data_memory_bytelane #(
    .ADDR_WIDTH(AW),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .write_enable(write_enable),
    .read_enable(read_enable),
    .mem_to_reg(mem_to_reg),
    .access_size(access_size),
    .load_unsigned(load_unsigned),
    .input_addr(input_addr),
    .input_data(input_data),
    .output_data(output_data),
    .read_valid(read_valid),
    .busy(busy),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  byte unsigned ref_mem [NB];
  logic [31:0]  exp_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input int unsigned a, input int unsigned n, input bit lu);
    logic [31:0] v;
    v = '0;
    for (int unsigned k = 0; k < n; k++) v |= 32'(ref_mem[(a + k) % NB]) << (8 * k);
    if (!lu && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic idle();
    write_enable = 1'b0;
    read_enable  = 1'b0;
    mem_to_reg   = 1'b0;
  endtask

  // One request cycle: predict from the model, clock it, compare all outputs.
  task automatic op(input bit we, input bit re, input bit m2r, input logic [1:0] sz,
                    input bit lu, input logic [31:0] addr, input logic [31:0] data,
                    input string tag);
    int unsigned a, n;
    bit mis;
    a   = addr % NB;
    n   = nbytes(sz);
    mis = (sz == 2'd3) || (a % n != 0);
    if (re) exp_out = !m2r ? data : (mis ? 32'h0 : model_load(a, n, lu));
    if (we && !mis)
      for (int unsigned k = 0; k < n; k++) ref_mem[(a + k) % NB] = 8'(data >> (8 * k));
    write_enable  = we;
    read_enable   = re;
    mem_to_reg    = m2r;
    access_size   = sz;
    load_unsigned = lu;
    input_addr    = addr;
    input_data    = data;
    @(posedge clk); #1;
    chk({tag, ":read_valid"}, 32'(read_valid), 32'(re));
    chk({tag, ":misaligned"}, 32'(misaligned), 32'((we || re) && mis));
    chk({tag, ":output_data"}, output_data, exp_out);
    chk({tag, ":busy"}, 32'(busy), 32'd0);
  endtask

  int cnt;

  initial begin
    for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;
    exp_out = '0;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst:busy", 32'(busy), 32'd1);
      chk("rst:read_valid", 32'(read_valid), 32'd0);
      chk("rst:misaligned", 32'(misaligned), 32'd0);
      chk("rst:output_data", output_data, 32'h0);
    end
    reset = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("sweep_len", 32'(cnt), 32'(DEPTH));

    for (int i = 0; i < DEPTH; i++) op(0, 1, 1, 2'd2, 0, 32'(4 * i), 32'h0, "clr_rd");
    idle();

    // Reset pulse mid-sweep; requests during the sweep are ignored
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("sweep1:busy", 32'(busy), 32'd1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("restart:busy", 32'(busy), 32'd1);
    reset = 1'b0;
    write_enable = 1'b1;
    read_enable  = 1'b1;
    mem_to_reg   = 1'b1;
    access_size  = 2'd2;
    input_addr   = 32'h08;
    input_data   = 32'hAAAAAAAA;
    cnt = 0;
    while (busy && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      chk("busy:read_valid", 32'(read_valid), 32'd0);
      chk("busy:misaligned", 32'(misaligned), 32'd0);
      chk("busy:output_data", output_data, 32'h0);
    end
    chk("restart_len", 32'(cnt), 32'(DEPTH));
    idle();
    op(0, 1, 1, 2'd2, 0, 32'h08, 32'h0, "busy_store_dropped");
    chk("busy_store_lit", output_data, 32'h0);

    // Sub-word stores and loads
    op(1, 0, 0, 2'd2, 0, 32'h10, 32'h8899AABB, "st_w10");
    op(1, 0, 0, 2'd0, 0, 32'h13, 32'h000000F0, "st_b13");
    op(0, 1, 1, 2'd0, 0, 32'h13, 32'h0, "ld_sb13");
    chk("ld_sb13_lit", output_data, 32'hFFFFFFF0);
    op(0, 1, 1, 2'd1, 1, 32'h12, 32'h0, "ld_uh12");
    chk("ld_uh12_lit", output_data, 32'h0000F099);
    op(0, 1, 1, 2'd2, 0, 32'h10, 32'h0, "ld_w10");
    chk("ld_w10_lit", output_data, 32'hF099AABB);

    // Misalignment
    op(1, 0, 0, 2'd1, 0, 32'h21, 32'h0000BEEF, "st_h21_mis");
    chk("st_h21_mis_lit", 32'(misaligned), 32'd1);
    op(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, "mis_pulse_end");
    op(0, 1, 1, 2'd2, 0, 32'h20, 32'h0, "ld_w20_unchanged");
    op(0, 1, 1, 2'd2, 0, 32'h22, 32'h0, "ld_w22_mis");
    chk("ld_w22_mis_lit", output_data, 32'h0);
    op(0, 1, 1, 2'd3, 0, 32'h00, 32'h0, "ld_rsvd");

    // Read-before-write on the same word (0x40 wraps to word 0)
    op(1, 0, 0, 2'd2, 0, 32'h40, 32'hDEADBEEF, "st_w40");
    op(1, 1, 1, 2'd2, 0, 32'h40, 32'h12345678, "rbw");
    chk("rbw_lit", output_data, 32'hDEADBEEF);
    op(0, 1, 1, 2'd2, 0, 32'h40, 32'h0, "rbw_next");
    chk("rbw_next_lit", output_data, 32'h12345678);

    // Address wrap and ALU bypass
    op(1, 0, 0, 2'd2, 0, 32'h44, 32'hCAFEF00D, "st_w44");
    op(0, 1, 1, 2'd2, 0, 32'h04, 32'h0, "ld_w04");
    chk("ld_w04_lit", output_data, 32'hCAFEF00D);
    op(0, 1, 0, 2'd2, 0, 32'h0, 32'h00000055, "bypass");
    chk("bypass_lit", output_data, 32'h00000055);
    op(0, 0, 0, 2'd2, 0, 32'h0, 32'h0, "hold");
    chk("hold_lit", output_data, 32'h00000055);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      op(1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
         1'($urandom), $urandom, $urandom, "rand");
    end
    idle();
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
